// File: rtl/alu_issue_ctrl.sv
// Issues one decoded MIPS R-type / SPECIAL2 operation to an external combinational
// ALU and returns the registered result with a sticky, op-masked NZCV status.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              out_illegal,
  output logic              out_exc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] OP_AND  = 5'd0,  OP_OR   = 5'd1,  OP_XOR  = 5'd2,  OP_NOR = 5'd3;
  localparam logic [4:0] OP_SLL  = 5'd5,  OP_SRL  = 5'd7,  OP_ADDU = 5'd8,  OP_SUBU = 5'd9;
  localparam logic [4:0] OP_ADD  = 5'd10, OP_SUB  = 5'd11, OP_SLT  = 5'd12, OP_SLTU = 5'd13;
  localparam logic [4:0] OP_CLO  = 5'd14, OP_CLZ  = 5'd15;
  localparam int FN = 3, FZ = 2, FC = 1, FV = 0;
  localparam int PADW = DATA_W - 5;

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                illegal_q, illegal_d;
  logic                exc_q, exc_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [5:0]          opc, funct;
  logic [4:0]          shamt;
  logic                dec_legal;
  logic [4:0]          dec_op;
  logic [DATA_W-1:0]   dec_a, dec_b;
  logic                unused_instr;

  assign opc          = instr[31:26];
  assign funct        = instr[5:0];
  assign shamt        = instr[10:6];
  assign unused_instr = ^instr[25:11];

  // Shifts take the value from rt and the amount from shamt or rs[4:0]
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_AND;
    dec_a     = rs_val;
    dec_b     = rt_val;
    if (opc == 6'h00) begin
      case (funct)
        6'h24: dec_op = OP_AND;
        6'h25: dec_op = OP_OR;
        6'h26: dec_op = OP_XOR;
        6'h27: dec_op = OP_NOR;
        6'h00: begin dec_op = OP_SLL; dec_a = rt_val; dec_b = {{PADW{1'b0}}, shamt}; end
        6'h04: begin dec_op = OP_SLL; dec_a = rt_val; dec_b = {{PADW{1'b0}}, rs_val[4:0]}; end
        6'h02: begin dec_op = OP_SRL; dec_a = rt_val; dec_b = {{PADW{1'b0}}, shamt}; end
        6'h06: begin dec_op = OP_SRL; dec_a = rt_val; dec_b = {{PADW{1'b0}}, rs_val[4:0]}; end
        6'h21: dec_op = OP_ADDU;
        6'h23: dec_op = OP_SUBU;
        6'h20: dec_op = OP_ADD;
        6'h22: dec_op = OP_SUB;
        6'h2A: dec_op = OP_SLT;
        6'h2B: dec_op = OP_SLTU;
        default: dec_legal = 1'b0;
      endcase
    end else if (opc == 6'h1C) begin
      dec_b = '0;
      case (funct)
        6'h21: dec_op = OP_CLO;
        6'h20: dec_op = OP_CLZ;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    exc_d     = exc_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          illegal_d = ~dec_legal;
          exc_d     = 1'b0;
          if (dec_legal) begin
            op_d    = dec_op;
            a_d     = dec_a;
            b_d     = dec_b;
            state_d = EXEC;
          end else begin
            // ALU inputs are left untouched so the ALU sees no new operation
            result_d = '0;
            state_d  = RESP;
          end
        end
      end
      EXEC: begin
        result_d = alu_result;
        if (op_q == OP_SLL || op_q == OP_SRL || op_q == OP_ADDU || op_q == OP_SUBU)
          flags_d[FC] = alu_c;
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          flags_d[FN] = alu_n;
          flags_d[FZ] = alu_z;
          flags_d[FV] = alu_v;
          exc_d       = alu_v;
        end
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
          if (!illegal_q) retired_d = retired_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      exc_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      exc_q     <= exc_d;
      retired_q <= retired_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == RESP);
  assign alu_opcode  = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign out_result  = result_q;
  assign out_flags   = flags_q;
  assign out_illegal = illegal_q;
  assign out_exc     = exc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU answers the DUT, and an
// instruction-level reference model predicts every response.
module tb_alu_issue_ctrl;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       instr = '0, rs_val = '0, rt_val = '0;
  logic [4:0]        alu_opcode;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic              alu_c, alu_n, alu_z, alu_v;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;
  logic              out_illegal, out_exc;
  logic [CNT_W-1:0]  retired;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_flags = '0;
  int          exp_ret = 0;
  logic [4:0]  last_op = '0;
  logic [31:0] last_a = '0, last_b = '0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_illegal(out_illegal), .out_exc(out_exc), .retired(retired)
  );

  // ALU stand-in: flags it does not compute are random, so unmasked capture shows up
  logic [3:0]  noise = 4'h0;
  logic [32:0] m_w;
  logic        m_hit;
  int          m_sh;
  always @(posedge clk) noise <= 4'($urandom);
  always_comb begin
    alu_result = '0;
    alu_n = noise[3]; alu_z = noise[2]; alu_c = noise[1]; alu_v = noise[0];
    m_w = '0; m_hit = 1'b0; m_sh = int'(alu_b[4:0]);
    case (alu_opcode)
      5'd0: alu_result = alu_a & alu_b;
      5'd1: alu_result = alu_a | alu_b;
      5'd2: alu_result = alu_a ^ alu_b;
      5'd3: alu_result = ~(alu_a | alu_b);
      5'd5: begin alu_result = alu_a << m_sh; alu_c = (m_sh == 0) ? 1'b0 : alu_a[32-m_sh]; end
      5'd7: begin alu_result = alu_a >> m_sh; alu_c = (m_sh == 0) ? 1'b0 : alu_a[m_sh-1]; end
      5'd8: begin m_w = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = m_w[31:0]; alu_c = m_w[32]; end
      5'd9: begin alu_result = alu_a - alu_b; alu_c = (alu_a >= alu_b); end
      5'd10: begin
        alu_result = alu_a + alu_b; alu_n = alu_result[31]; alu_z = (alu_result == 0);
        alu_v = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      5'd11: begin
        alu_result = alu_a - alu_b; alu_n = alu_result[31]; alu_z = (alu_result == 0);
        alu_v = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      5'd12: alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      5'd13: alu_result = {31'b0, (alu_a < alu_b)};
      5'd14: for (int i = 31; i >= 0; i--) begin
               if (!alu_a[i]) m_hit = 1'b1;
               if (!m_hit) alu_result = alu_result + 32'd1;
             end
      5'd15: for (int i = 31; i >= 0; i--) begin
               if (alu_a[i]) m_hit = 1'b1;
               if (!m_hit) alu_result = alu_result + 32'd1;
             end
      default: ;
    endcase
  end

  typedef struct {
    bit          legal;
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  flags;
    bit          exc;
  } exp_t;

  typedef struct {
    int               lat;
    logic [4:0]       op;
    logic [31:0]      a, b, res;
    logic [3:0]       flags;
    logic             ill, exc;
    bit               stable, busy;
    logic [CNT_W-1:0] ret;
  } obs_t;

  // Instruction-level semantics; flags are {N,Z,C,V}
  function automatic exp_t ref_model(input logic [31:0] ins, rs, rt, input logic [3:0] fl);
    exp_t e; longint s; logic [63:0] wide; int sh; int cnt; logic want;
    e.legal = 1; e.op = 0; e.a = rs; e.b = rt; e.res = 0; e.flags = fl; e.exc = 0;
    sh = int'(ins[10:6]); cnt = 0; want = 1'b0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h24: begin e.op = 0; e.res = rs & rt; end
        6'h25: begin e.op = 1; e.res = rs | rt; end
        6'h26: begin e.op = 2; e.res = rs ^ rt; end
        6'h27: begin e.op = 3; e.res = ~(rs | rt); end
        6'h00, 6'h04: begin
          if (ins[5:0] == 6'h04) sh = int'(rs[4:0]);
          e.op = 5; e.a = rt; e.b = 32'(sh);
          wide = {32'h0, rt} << sh; e.res = wide[31:0]; e.flags[1] = wide[32];
        end
        6'h02, 6'h06: begin
          if (ins[5:0] == 6'h06) sh = int'(rs[4:0]);
          e.op = 7; e.a = rt; e.b = 32'(sh);
          wide = {rt, 32'h0} >> sh; e.res = wide[63:32]; e.flags[1] = wide[31];
        end
        6'h21: begin e.op = 8; s = longint'(rs) + longint'(rt); e.res = s[31:0]; e.flags[1] = s[32]; end
        6'h23: begin e.op = 9; e.res = rs - rt; e.flags[1] = (rs >= rt); end
        6'h20, 6'h22: begin
          e.op = (ins[5:0] == 6'h20) ? 5'd10 : 5'd11;
          if (e.op == 5'd10) s = longint'($signed(rs)) + longint'($signed(rt));
          else               s = longint'($signed(rs)) - longint'($signed(rt));
          e.res = s[31:0];
          e.flags[3] = e.res[31]; e.flags[2] = (e.res == 0);
          e.flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          e.exc = e.flags[0];
        end
        6'h2A: begin e.op = 12; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        6'h2B: begin e.op = 13; e.res = (rs < rt) ? 32'd1 : 32'd0; end
        default: e.legal = 0;
      endcase
    end else if (ins[31:26] == 6'h1C && (ins[5:0] == 6'h21 || ins[5:0] == 6'h20)) begin
      want = (ins[5:0] == 6'h21);
      e.op = want ? 5'd14 : 5'd15; e.b = 0;
      for (int i = 31; i >= 0 && rs[i] == want; i--) cnt++;
      e.res = 32'(cnt);
    end else begin
      e.legal = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 15'h0, sh, fn};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'h00000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic commit(input exp_t e);
    exp_flags = e.flags;
    if (e.legal) begin
      exp_ret = (exp_ret + 1) % (1 << CNT_W);
      last_op = e.op; last_a = e.a; last_b = e.b;
    end
  endtask

  // Drives one request, scrambles inputs after the accept edge, then holds
  // out_ready low for 'stall' cycles before completing the response handshake.
  task automatic send(input logic [31:0] ins, rs, rt, input int stall, output obs_t o);
    @(negedge clk);
    in_valid = 1'b1; instr = ins; rs_val = rs; rt_val = rt;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = $urandom; rs_val = $urandom; rt_val = $urandom;
    o.op = alu_opcode; o.a = alu_a; o.b = alu_b;
    o.busy = !in_ready;
    o.lat = 1;
    while (!out_valid && o.lat < 8) begin
      @(posedge clk); #1;
      o.lat++;
      if (in_ready) o.busy = 0;
    end
    o.res = out_result; o.flags = out_flags; o.ill = out_illegal; o.exc = out_exc;
    o.stable = 1;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_result !== o.res || out_flags !== o.flags ||
          out_illegal !== o.ill || out_exc !== o.exc || alu_opcode !== o.op) o.stable = 0;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    o.ret = retired;
    if (out_valid || !in_ready) o.stable = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu: op=%0d a=%h b=%h want 0", alu_opcode, alu_a, alu_b); end
    checks++; if ({out_result, out_flags, out_illegal, out_exc} !== '0 || retired !== '0) begin errors++; $display("FAIL reset_outputs: res=%h flags=%b ill=%b exc=%b ret=%0d want 0", out_result, out_flags, out_illegal, out_exc, retired); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_overflow;
    obs_t o; exp_t e;
    e = ref_model(rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'h1, exp_flags);
    send(rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'h1, 0, o);
    checks++; if (o.op !== 5'd10) begin errors++; $display("FAIL add_opcode: got %0d want 10", o.op); end
    checks++; if (o.res !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", o.res); end
    checks++; if (o.flags !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b want 1001", o.flags); end
    checks++; if (o.exc !== 1'b1 || o.ill !== 1'b0) begin errors++; $display("FAIL add_exc: exc=%b ill=%b want 1/0", o.exc, o.ill); end
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL add_latency: got T+%0d want T+2", o.lat); end
    checks++; if (o.ret !== CNT_W'(exp_ret + 1)) begin errors++; $display("FAIL add_retired: got %0d want %0d", o.ret, exp_ret + 1); end
    commit(e);
  endtask

  task automatic test_sll;
    obs_t o; exp_t e; logic [3:0] want;
    want = {exp_flags[3:2], 1'b1, exp_flags[0]};
    e = ref_model(rtype(6'h00, 5'd4), 32'hDEADBEEF, 32'h12345678, exp_flags);
    send(rtype(6'h00, 5'd4), 32'hDEADBEEF, 32'h12345678, 1, o);
    checks++; if (o.op !== 5'd5 || o.a !== 32'h12345678 || o.b !== 32'd4) begin errors++; $display("FAIL sll_alu_inputs: op=%0d a=%h b=%h want 5/12345678/4", o.op, o.a, o.b); end
    checks++; if (o.res !== 32'h23456780) begin errors++; $display("FAIL sll_result: got %h want 23456780", o.res); end
    checks++; if (o.flags !== want) begin errors++; $display("FAIL sll_flags: got %b want %b", o.flags, want); end
    checks++; if (o.exc !== 1'b0) begin errors++; $display("FAIL sll_exc: got %b want 0", o.exc); end
    commit(e);
  endtask

  task automatic test_clz;
    obs_t o; exp_t e; logic [31:0] ins;
    ins = {6'h1C, 20'h0, 6'h20};
    e = ref_model(ins, 32'h000000FF, 32'h0BADF00D, exp_flags);
    send(ins, 32'h000000FF, 32'h0BADF00D, 0, o);
    checks++; if (o.op !== 5'd15 || o.a !== 32'hFF || o.b !== 32'h0) begin errors++; $display("FAIL clz_alu_inputs: op=%0d a=%h b=%h want 15/ff/0", o.op, o.a, o.b); end
    checks++; if (o.res !== 32'd24) begin errors++; $display("FAIL clz_result: got %0d want 24", o.res); end
    checks++; if (o.flags !== exp_flags) begin errors++; $display("FAIL clz_flags: got %b want %b", o.flags, exp_flags); end
    commit(e);
  endtask

  task automatic test_illegal_backpressure;
    obs_t o; exp_t e;
    e = ref_model(rtype(6'h3F, 5'd0), 32'h11111111, 32'h22222222, exp_flags);
    send(rtype(6'h3F, 5'd0), 32'h11111111, 32'h22222222, 5, o);
    checks++; if (o.ill !== 1'b1 || o.exc !== 1'b0) begin errors++; $display("FAIL illegal_flag: ill=%b exc=%b want 1/0", o.ill, o.exc); end
    checks++; if (o.res !== 32'h0) begin errors++; $display("FAIL illegal_result: got %h want 0", o.res); end
    checks++; if (o.flags !== exp_flags) begin errors++; $display("FAIL illegal_flags: got %b want %b", o.flags, exp_flags); end
    checks++; if (o.ret !== CNT_W'(exp_ret)) begin errors++; $display("FAIL illegal_retired: got %0d want %0d", o.ret, exp_ret); end
    checks++; if (o.op !== last_op || o.a !== last_a || o.b !== last_b) begin errors++; $display("FAIL illegal_alu_hold: op=%0d a=%h b=%h want %0d/%h/%h", o.op, o.a, o.b, last_op, last_a, last_b); end
    checks++; if (o.lat !== 1) begin errors++; $display("FAIL illegal_latency: got T+%0d want T+1", o.lat); end
    checks++; if (!o.stable || !o.busy) begin errors++; $display("FAIL backpressure_hold: stable=%b busy=%b want 1/1", o.stable, o.busy); end
    commit(e);
  endtask

  localparam logic [5:0] RFUN [14] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h04, 6'h02,
                                       6'h06, 6'h21, 6'h23, 6'h20, 6'h22, 6'h2A, 6'h2B};

  task automatic test_random;
    obs_t o; exp_t e; logic [31:0] ins, rs, rt, r; int idx;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 18);
      r = $urandom;
      if (idx < 14)       ins = {6'h00, r[25:6], RFUN[idx]};
      else if (idx == 14) ins = {6'h1C, r[25:6], 6'h21};
      else if (idx == 15) ins = {6'h1C, r[25:6], 6'h20};
      else if (idx == 16) ins = {6'h00, r[25:6], 6'h3F};
      else if (idx == 17) ins = {6'h1C, r[25:6], 6'h02};
      else                ins = {6'h08, r[25:0]};
      rs = pick(); rt = pick();
      e = ref_model(ins, rs, rt, exp_flags);
      send(ins, rs, rt, $urandom_range(0, 2), o);
      checks++; if (o.lat !== (e.legal ? 2 : 1)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d ins=%h", n, o.lat, e.legal ? 2 : 1, ins); end
      checks++;
      if (e.legal && (o.op !== e.op || o.a !== e.a || o.b !== e.b)) begin errors++; $display("FAIL rnd_alu_inputs[%0d]: op=%0d a=%h b=%h want %0d/%h/%h", n, o.op, o.a, o.b, e.op, e.a, e.b); end
      else if (!e.legal && (o.op !== last_op || o.a !== last_a || o.b !== last_b)) begin errors++; $display("FAIL rnd_alu_hold[%0d]: op=%0d a=%h b=%h want %0d/%h/%h", n, o.op, o.a, o.b, last_op, last_a, last_b); end
      checks++; if (o.res !== e.res) begin errors++; $display("FAIL rnd_result[%0d]: got %h want %h ins=%h", n, o.res, e.res, ins); end
      checks++; if (o.flags !== e.flags) begin errors++; $display("FAIL rnd_flags[%0d]: got %b want %b ins=%h", n, o.flags, e.flags, ins); end
      checks++; if (o.ill !== !e.legal || o.exc !== e.exc) begin errors++; $display("FAIL rnd_status[%0d]: ill=%b exc=%b want %b/%b", n, o.ill, o.exc, !e.legal, e.exc); end
      commit(e);
      checks++; if (o.ret !== CNT_W'(exp_ret)) begin errors++; $display("FAIL rnd_retired[%0d]: got %0d want %0d", n, o.ret, exp_ret); end
      checks++; if (!o.stable || !o.busy) begin errors++; $display("FAIL rnd_hold[%0d]: stable=%b busy=%b want 1/1", n, o.stable, o.busy); end
    end
  endtask

  task automatic test_counter_wrap;
    obs_t o; exp_t e; int start; logic [3:0] fl0;
    start = exp_ret; fl0 = exp_flags;
    for (int n = 0; n < 17; n++) begin
      e = ref_model(rtype(6'h24, 5'd0), 32'hAAAAAAAA, 32'h55555555, exp_flags);
      send(rtype(6'h24, 5'd0), 32'hAAAAAAAA, 32'h55555555, 0, o);
      checks++; if (o.res !== 32'h0 || o.lat !== 2) begin errors++; $display("FAIL wrap_and[%0d]: res=%h lat=%0d want 0/2", n, o.res, o.lat); end
      commit(e);
    end
    checks++; if (o.ret !== CNT_W'(start + 1)) begin errors++; $display("FAIL wrap_retired: got %0d want %0d", o.ret, (start + 1) % 16); end
    checks++; if (o.flags !== fl0) begin errors++; $display("FAIL wrap_flags: got %b want %b", o.flags, fl0); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    @(negedge clk);
    in_valid = 1'b1; instr = rtype(6'h22, 5'd0); rs_val = 32'h80000000; rt_val = 32'h1;
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_exec: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); end
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (out_flags !== 4'b0000 || retired !== '0) begin errors++; $display("FAIL async_reset_state: flags=%b ret=%0d want 0000/0", out_flags, retired); end
    checks++; if ({alu_opcode, alu_a, alu_b, out_result, out_illegal, out_exc} !== '0) begin errors++; $display("FAIL async_reset_data: op=%0d a=%h b=%h res=%h want 0", alu_opcode, alu_a, alu_b, out_result); end
    @(negedge clk); rst_n = 1'b1;
    exp_flags = '0; exp_ret = 0; last_op = '0; last_a = '0; last_b = '0;
    send(rtype(6'h21, 5'd0), 32'd1, 32'd2, 0, o);
    checks++; if (o.res !== 32'd3 || o.ret !== CNT_W'(1) || o.lat !== 2) begin errors++; $display("FAIL after_reset_op: res=%h ret=%0d lat=%0d want 3/1/2", o.res, o.ret, o.lat); end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sll;
    test_clz;
    test_illegal_backpressure;
    test_random;
    test_counter_wrap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU32bit opcode/operand interface.
- Accepts a MIPS R-type or SPECIAL2 instruction word plus register operands over a valid/ready handshake.
- Decodes the funct field to the 5-bit ALU opCode and drives the combinational ALU for one cycle.
- Registers result and masked NZCV into a sticky status register; presents a response over a second valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported).
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  controller can accept a request.
- instr  in  32  instruction word.
- rs_val  in  32  value of register rs.
- rt_val  in  32  value of register rt.
- alu_opcode  out  5  to ALU opCode.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_result  in  32  from ALU result.
- alu_c, alu_n, alu_z, alu_v  in  1 each  from ALU flags.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumer ready.
- out_result  out  32  registered result.
- out_flags  out  4  sticky status {N,Z,C,V}.
- out_illegal  out  1  undecodable instruction.
- out_exc  out  1  signed overflow trap (ADD/SUB with V=1).
- retired  out  CNT_W  count of completed legal operations; wraps to 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, alu_opcode=0, alu_a=0, alu_b=0, out_result=0, out_flags=0, out_illegal=0, out_exc=0, retired=0. Reset mid-operation aborts; the pending response is lost.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready=1. On in_valid, capture decoded opcode/operands at the edge and go to EXEC, or go to RESP if illegal.
  - EXEC: in_ready=0. ALU inputs held stable. At the end of the cycle, capture alu_result and flags, then go to RESP.
  - RESP: out_valid=1, outputs held stable. On out_ready, go to IDLE. No new accept in RESP.
- Latency: accept edge T; out_valid high from T+2. Minimum throughput is one op per 3 cycles.
- Decode, opcode 0x00 (SPECIAL), by funct:
  - 0x24 AND→0, 0x25 OR→1, 0x26 XOR→2, 0x27 NOR→3: a=rs, b=rt.
  - 0x00 SLL→5: a=rt, b=zero-extended shamt instr[10:6].
  - 0x04 SLLV→5: a=rt, b={27'b0, rs[4:0]}.
  - 0x02 SRL→7: a=rt, b=shamt.
  - 0x06 SRLV→7: a=rt, b={27'b0, rs[4:0]}.
  - 0x21 ADDU→8, 0x23 SUBU→9, 0x20 ADD→10, 0x22 SUB→11, 0x2A SLT→12, 0x2B SLTU→13: a=rs, b=rt.
- Decode, opcode 0x1C (SPECIAL2): funct 0x21 CLO→14, 0x20 CLZ→15; a=rs, b=0.
- Any other opcode/funct is illegal: out_illegal=1, out_result=0, flags unchanged, ALU not driven (inputs keep previous values), retired unchanged.
- Flag masking (the ALU leaves flags stale for other ops):
  - C updated only for opcodes 5, 7, 8, 9.
  - N, Z, V updated only for 10, 11.
  - All other bits hold their previous value.
- out_exc=1 iff opcode 10/11 and alu_v=1. out_result still carries the wrapped sum; the consumer decides on writeback.
- retired increments by 1 on the RESP→IDLE transition of each legal op. It wraps from 2^CNT_W−1 to 0.
- out_illegal and out_exc are valid only while out_valid=1. They clear on the next accept.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC. Required: out_valid=0, in_ready=1, out_flags=0000, retired=0 immediately, with no clock edge needed.
- ADD overflow: instr funct 0x20, rs_val=7FFFFFFF, rt_val=00000001. Required: alu_opcode=10; out_result=80000000; out_flags N=1, Z=0, V=1; out_exc=1; out_valid at T+2.
- SLL: shamt=4, rt_val=12345678. Required: alu_opcode=5, alu_a=12345678, alu_b=4, out_result=23456780, C=1, N/Z/V unchanged from the prior op.
- CLZ: instr opcode 0x1C funct 0x20, rs_val=000000FF. Required: alu_opcode=15, out_result=24, flags unchanged.
- Illegal and back-pressure: illegal funct 0x3F. Required: out_illegal=1, out_result=0, retired unchanged. Then hold out_ready=0 for 5 cycles; outputs stay stable and in_ready=0 throughout.
- Counter wrap: with CNT_W=4, issue 17 legal ANDs (AAAAAAAA & 55555555 → 0). Required: retired=1 and flags unchanged.
